// File: rtl/pipe_pkg.sv
// Shared defaults and entry type for pipeline stage registers.
// Stages built with other widths use their own parameters; entry_t covers the default 32/32 case.
package pipe_pkg;
  localparam int          PC_W_DEF    = 32;
  localparam int          INS_W_DEF   = 32;
  localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] ins;
  } entry_t;
endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus data word. Latency: 1 cycle, load/kill/clear act on the next edge.
// No backpressure of its own: the parent decides when to set it. Priority is clear > set > kill.
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic         kill,
  input  logic         clear,
  input  logic [W-1:0] set_dat,
  output logic         vld,
  output logic [W-1:0] dat
);
  logic         vld_d, vld_q;
  logic [W-1:0] dat_d, dat_q;

  // kill drops the valid bit only; data is kept so a bubble still shows the last pc
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (set) begin
      vld_d = 1'b1;
      dat_d = set_dat;
    end else if (kill) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register for {pc, ins} with a 2-entry skid buffer. Latency: 1 cycle, 1 entry/cycle.
// Backpressure: in_ready is registered (low only while the skid slot holds an entry); flush empties both slots.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               PC_W    = PC_W_DEF,
  parameter int               INS_W   = INS_W_DEF,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF),
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int W = PC_W + INS_W;

  logic         main_vld, skid_vld;
  logic [W-1:0] main_dat, skid_dat, main_set_dat;
  logic         main_set, main_kill, skid_set, skid_kill;
  logic         acc, main_free;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign in_ready  = !skid_vld;
  assign acc       = in_valid && in_ready;
  assign main_free = !main_vld || out_ready;

  // skid is only ever valid together with main, so when main frees up the skid entry moves first
  always_comb begin
    main_set     = 1'b0;
    main_kill    = 1'b0;
    skid_set     = 1'b0;
    skid_kill    = 1'b0;
    main_set_dat = {in_pc, in_ins};
    if (main_free) begin
      if (skid_vld) begin
        main_set     = 1'b1;
        main_set_dat = skid_dat;
        skid_kill    = 1'b1;
      end else if (acc) begin
        main_set = 1'b1;
      end else begin
        main_kill = 1'b1;
      end
    end else if (acc) begin
      skid_set = 1'b1;
    end
  end

  pipe_slot #(.W(W)) u_main (
    .clk(clk), .rst(rst), .set(main_set), .kill(main_kill), .clear(flush),
    .set_dat(main_set_dat), .vld(main_vld), .dat(main_dat)
  );

  pipe_slot #(.W(W)) u_skid (
    .clk(clk), .rst(rst), .set(skid_set), .kill(skid_kill), .clear(flush),
    .set_dat({in_pc, in_ins}), .vld(skid_vld), .dat(skid_dat)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid = main_vld;
  assign out_pc    = main_dat[W-1:INS_W];
  assign out_ins   = main_vld ? main_dat[INS_W-1:0] : NOP_INS;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a queue-based model of the stage.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_ins;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_ins;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  entry_t      mq[$];
  logic [31:0] m_last_pc;
  int          m_cnt;
  bit          chk_en;

  pipe_stage_skid #(
    .PC_W(32), .INS_W(32), .NOP_INS(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        e_vld;
    logic [31:0] e_pc, e_ins;
    e_vld = (mq.size() > 0);
    e_pc  = e_vld ? mq[0].pc  : m_last_pc;
    e_ins = e_vld ? mq[0].ins : NOP;
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_vld});
    chk("in_ready",  {31'b0, in_ready},  {31'b0, (mq.size() < 2)});
    chk("out_pc",    out_pc,  e_pc);
    chk("out_ins",   out_ins, e_ins);
    chk("stall_cnt", {28'b0, stall_cnt}, m_cnt);
  endtask

  // Stage as an ordered list of at most two entries
  task automatic model_update();
    bit acc;
    if (!rst) begin
      mq.delete();
      m_last_pc = '0;
      m_cnt     = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && !out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
      if (flush) begin
        mq.delete();
        m_last_pc = '0;
      end else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: in_pc, ins: in_ins});
        if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] pc, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_ins    = {pc[15:0] ^ 16'hBEEF, pc[15:0]};
    out_ready = ordy;
    @(negedge clk);
    if (chk_en) check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_ins = '0; out_ready = 1'b0;
    chk_en = 1'b0; m_last_pc = '0; m_cnt = 0;
    @(posedge clk); #1;

    // 1 reset with in_valid high
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h104, 1'b1);
    chk_en = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc",    out_pc, 32'd0);
    chk("rst_out_ins",   out_ins, NOP);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);

    // 2 streaming
    step(1'b1, 1'b0, 1'b1, 32'h00, 1'b1);
    chk("t2_pc0", out_pc, 32'h00);
    step(1'b1, 1'b0, 1'b1, 32'h04, 1'b1);
    chk("t2_pc4", out_pc, 32'h04);
    step(1'b1, 1'b0, 1'b1, 32'h08, 1'b1);
    chk("t2_pc8", out_pc, 32'h08);
    chk("t2_in_ready", {31'b0, in_ready}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // 3 backpressure, 0x18 held until accepted
    step(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h14, 1'b0);
    chk("t3_hold_pc", out_pc, 32'h10);
    chk("t3_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h18, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h18, 1'b0);
    chk("t3_still_held", out_pc, 32'h10);
    step(1'b1, 1'b0, 1'b1, 32'h18, 1'b1);
    chk("t3_skid_moved", out_pc, 32'h14);
    chk("t3_ready_back", {31'b0, in_ready}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h18, 1'b1);
    chk("t3_last", out_pc, 32'h18);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // 4 flush at occupancy 2 with a same-cycle input
    step(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h24, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h28, 1'b0);
    chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_out_ins",   out_ins, NOP);
    chk("t4_out_pc",    out_pc, 32'd0);
    chk("t4_in_ready",  {31'b0, in_ready}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // 5 stall counter saturation, survives flush, cleared by reset
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h30, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_sat", {28'b0, stall_cnt}, 32'd15);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t5_flush_keeps", {28'b0, stall_cnt}, 32'd15);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_rst_clears", {28'b0, stall_cnt}, 32'd0);

    // 6 reset at occupancy 2
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h48, 1'b0);
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_in_ready",  {31'b0, in_ready}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), ($urandom & 32'hFFFF_FFFC),
           ($urandom_range(0, 2) != 0));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
